// File: rtl/obi_axi4l_bridge.sv
// Ibex request/grant/rvalid bus to AXI4-Lite master bridge, one access in flight.
// state  | meaning
// IDLE   | no access in flight; grant offered to the core
// WRITE  | AW/W issued, waiting for both handshakes and the B response
// READ   | AR issued, waiting for its handshake and the R response
module obi_axi4l_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   output logic                    awvalid_o,
   input  logic                    awready_i,
   output logic [ADDR_WIDTH-1:0]   awaddr_o,
   output logic [2:0]              awprot_o,
   output logic                    wvalid_o,
   input  logic                    wready_i,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic [DATA_WIDTH/8-1:0] wstrb_o,
   input  logic                    bvalid_i,
   output logic                    bready_o,
   input  logic [1:0]              bresp_i,
   output logic                    arvalid_o,
   input  logic                    arready_i,
   output logic [ADDR_WIDTH-1:0]   araddr_o,
   output logic [2:0]              arprot_o,
   input  logic                    rvalid_i,
   output logic                    rready_o,
   input  logic [DATA_WIDTH-1:0]   rdata_i,
   input  logic [1:0]              rresp_i
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_awvalid, w_awvalid_nxt;
   logic                    r_wvalid, w_wvalid_nxt;
   logic                    r_arvalid, w_arvalid_nxt;
   logic                    r_bready, w_bready_nxt;
   logic                    r_rready, w_rready_nxt;
   logic                    r_rvalid, w_rvalid_nxt;
   logic                    r_err, w_err_nxt;
   logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
   logic [ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_nxt;
   logic [ADDR_WIDTH-1:0]   r_araddr, w_araddr_nxt;
   logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
   logic [STRB_WIDTH-1:0]   r_wstrb, w_wstrb_nxt;
   logic [ADDR_WIDTH-1:0]   w_addr_aligned;
   logic                    w_unused;

   // Byte lane and response-type bits that carry no meaning on this path.
   assign w_unused       = ^{addr_i[1:0], bresp_i[0], rresp_i[0]};
   assign w_addr_aligned = {addr_i[ADDR_WIDTH-1:2], 2'b00};

   assign gnt_o     = req_i && (r_state == S_IDLE) && !rst;
   assign rvalid_o  = r_rvalid;
   assign rdata_o   = r_rdata;
   assign err_o     = r_err;
   assign awvalid_o = r_awvalid;
   assign awaddr_o  = r_awaddr;
   assign awprot_o  = 3'b000;
   assign wvalid_o  = r_wvalid;
   assign wdata_o   = r_wdata;
   assign wstrb_o   = r_wstrb;
   assign bready_o  = r_bready;
   assign arvalid_o = r_arvalid;
   assign araddr_o  = r_araddr;
   assign arprot_o  = 3'b000;
   assign rready_o  = r_rready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_arvalid <= 1'b0;
         r_bready  <= 1'b0;
         r_rready  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
         r_awaddr  <= '0;
         r_araddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_awvalid <= w_awvalid_nxt;
         r_wvalid  <= w_wvalid_nxt;
         r_arvalid <= w_arvalid_nxt;
         r_bready  <= w_bready_nxt;
         r_rready  <= w_rready_nxt;
         r_rvalid  <= w_rvalid_nxt;
         r_err     <= w_err_nxt;
         r_rdata   <= w_rdata_nxt;
         r_awaddr  <= w_awaddr_nxt;
         r_araddr  <= w_araddr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_wstrb   <= w_wstrb_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_awvalid_nxt = r_awvalid;
      w_wvalid_nxt  = r_wvalid;
      w_arvalid_nxt = r_arvalid;
      w_bready_nxt  = r_bready;
      w_rready_nxt  = r_rready;
      w_rvalid_nxt  = 1'b0;
      w_err_nxt     = 1'b0;
      w_rdata_nxt   = '0;
      w_awaddr_nxt  = r_awaddr;
      w_araddr_nxt  = r_araddr;
      w_wdata_nxt   = r_wdata;
      w_wstrb_nxt   = r_wstrb;

      case (r_state)
         S_IDLE: begin
            if (gnt_o) begin
               if (we_i) begin
                  w_state_nxt   = S_WRITE;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_bready_nxt  = 1'b1;
                  w_awaddr_nxt  = w_addr_aligned;
                  w_wdata_nxt   = wdata_i;
                  w_wstrb_nxt   = be_i;
               end else begin
                  w_state_nxt   = S_READ;
                  w_arvalid_nxt = 1'b1;
                  w_rready_nxt  = 1'b1;
                  w_araddr_nxt  = w_addr_aligned;
               end
            end
         end
         S_WRITE: begin
            // AW and W retire independently; the B response closes the access.
            if (r_awvalid && awready_i) w_awvalid_nxt = 1'b0;
            if (r_wvalid && wready_i)   w_wvalid_nxt  = 1'b0;
            if (bvalid_i && r_bready) begin
               w_state_nxt   = S_IDLE;
               w_awvalid_nxt = 1'b0;
               w_wvalid_nxt  = 1'b0;
               w_bready_nxt  = 1'b0;
               w_rvalid_nxt  = 1'b1;
               w_err_nxt     = bresp_i[1];
            end
         end
         S_READ: begin
            if (r_arvalid && arready_i) w_arvalid_nxt = 1'b0;
            if (rvalid_i && r_rready) begin
               w_state_nxt   = S_IDLE;
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b0;
               w_rvalid_nxt  = 1'b1;
               w_rdata_nxt   = rdata_i;
               w_err_nxt     = rresp_i[1];
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
